// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: independent TX and RX dividers sharing one
// runtime-programmable integer+fractional divisor, with RX start-bit alignment.

// One oversample divider: period act_int clocks, stretched by one clock
// after every fractional accumulator overflow.
module baud_div_core #(
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              restart,
    input  logic              run,
    input  logic [DIV_W-1:0]  act_int,
    input  logic [FRAC_W-1:0] act_frac,
    output logic              os_tick_c
);

    logic [DIV_W-1:0]  os_cnt;
    logic [FRAC_W-1:0] frac_acc;
    logic              carry;
    logic              ext;
    logic              at_end_c;
    logic              hold_c;

    // Period end detection; a pending carry costs one extra clock at the end.
    always_comb begin
        at_end_c  = (os_cnt == act_int);
        hold_c    = carry && !ext;
        os_tick_c = run && !clear && !restart && at_end_c && !hold_c;
    end

    // Counter and accumulator; restart makes the current clock the first of a period.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            os_cnt   <= '0;
            frac_acc <= '0;
            carry    <= 1'b0;
            ext      <= 1'b0;
        end else if (clear) begin
            os_cnt   <= '0;
            frac_acc <= '0;
            carry    <= 1'b0;
            ext      <= 1'b0;
        end else if (restart) begin
            os_cnt   <= DIV_W'(1);
            frac_acc <= '0;
            carry    <= 1'b0;
            ext      <= 1'b0;
        end else if (run) begin
            if (at_end_c) begin
                if (hold_c) begin
                    ext <= 1'b1;
                end else begin
                    os_cnt            <= DIV_W'(1);
                    ext               <= 1'b0;
                    {carry, frac_acc} <= (FRAC_W+1)'(frac_acc) + (FRAC_W+1)'(act_frac);
                end
            end else begin
                os_cnt <= os_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// Top level: config handshake, TX divider, RX divider with alignment FSM.
module baud_gen_frac #(
    parameter int unsigned DIV_W    = 16,
    parameter int unsigned FRAC_W   = 4,
    parameter int unsigned OSR      = 16,
    parameter int unsigned DEF_INT  = 27,
    parameter int unsigned DEF_FRAC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  cfg_div_int,
    input  logic [FRAC_W-1:0] cfg_div_frac,
    input  logic              cfg_load,
    output logic              cfg_busy,
    output logic              cfg_err,
    input  logic              tx_en,
    input  logic              rx_en,
    input  logic              rx_start_align,
    output logic              tx_os_tick,
    output logic              tx_baud_tick,
    output logic              rx_os_tick,
    output logic              rx_half_baud_tick,
    output logic              rx_baud_tick
);

    localparam int unsigned BIT_W = $clog2(OSR);
    localparam logic [BIT_W-1:0] HALF_LAST = BIT_W'(OSR/2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(OSR - 1);

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_HALF = 2'd1,
        RX_RUN  = 2'd2
    } rx_state_t;

    logic [DIV_W-1:0]  act_int;
    logic [FRAC_W-1:0] act_frac;
    logic [DIV_W-1:0]  pend_int;
    logic [FRAC_W-1:0] pend_frac;
    logic              load_ok_c;
    logic              load_bad_c;
    logic              apply_c;

    logic              tx_os_c;
    logic [BIT_W-1:0]  tx_bit;

    rx_state_t         rx_state;
    rx_state_t         rx_state_nxt;
    logic [BIT_W-1:0]  rx_bit;
    logic [BIT_W-1:0]  rx_bit_nxt;
    logic              rx_os_nxt;
    logic              rx_half_nxt;
    logic              rx_baud_nxt;
    logic              rx_os_c;
    logic              rx_clear_c;
    logic              rx_restart_c;
    logic              rx_run_c;

    // Load classification and the idle condition that allows applying a pending divisor.
    always_comb begin
        load_ok_c  = cfg_load && (cfg_div_int >= DIV_W'(2));
        load_bad_c = cfg_load && (cfg_div_int <  DIV_W'(2));
        apply_c    = cfg_busy && !tx_en && (rx_state == RX_IDLE);
    end

    // Config handshake: capture wins over apply, so a load in an idle cycle applies one cycle later.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            act_int   <= DIV_W'(DEF_INT);
            act_frac  <= FRAC_W'(DEF_FRAC);
            pend_int  <= '0;
            pend_frac <= '0;
            cfg_busy  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= load_bad_c;
            if (load_ok_c) begin
                pend_int  <= cfg_div_int;
                pend_frac <= cfg_div_frac;
                cfg_busy  <= 1'b1;
            end else if (apply_c) begin
                act_int  <= pend_int;
                act_frac <= pend_frac;
                cfg_busy <= 1'b0;
            end
        end
    end

    baud_div_core #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_tx_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (!tx_en),
        .restart   (1'b0),
        .run       (tx_en),
        .act_int   (act_int),
        .act_frac  (act_frac),
        .os_tick_c (tx_os_c)
    );

    // TX bit counter and registered TX strobes.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            tx_bit       <= '0;
            tx_os_tick   <= 1'b0;
            tx_baud_tick <= 1'b0;
        end else if (!tx_en) begin
            tx_bit       <= '0;
            tx_os_tick   <= 1'b0;
            tx_baud_tick <= 1'b0;
        end else begin
            tx_os_tick   <= tx_os_c;
            tx_baud_tick <= tx_os_c && (tx_bit == BIT_LAST);
            if (tx_os_c) begin
                tx_bit <= (tx_bit == BIT_LAST) ? '0 : tx_bit + BIT_W'(1);
            end
        end
    end

    // RX divider control derived from the FSM and the alignment pulse.
    always_comb begin
        rx_clear_c   = !rx_en || ((rx_state == RX_IDLE) && !rx_start_align);
        rx_restart_c = rx_en && rx_start_align;
        rx_run_c     = (rx_state != RX_IDLE);
    end

    baud_div_core #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_rx_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (rx_clear_c),
        .restart   (rx_restart_c),
        .run       (rx_run_c),
        .act_int   (act_int),
        .act_frac  (act_frac),
        .os_tick_c (rx_os_c)
    );

    // RX state register and registered RX strobes.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rx_state          <= RX_IDLE;
            rx_bit            <= '0;
            rx_os_tick        <= 1'b0;
            rx_half_baud_tick <= 1'b0;
            rx_baud_tick      <= 1'b0;
        end else begin
            rx_state          <= rx_state_nxt;
            rx_bit            <= rx_bit_nxt;
            rx_os_tick        <= rx_os_nxt;
            rx_half_baud_tick <= rx_half_nxt;
            rx_baud_tick      <= rx_baud_nxt;
        end
    end

    // RX next state: disable beats alignment, alignment beats normal counting.
    always_comb begin
        rx_state_nxt = rx_state;
        rx_bit_nxt   = rx_bit;
        rx_os_nxt    = 1'b0;
        rx_half_nxt  = 1'b0;
        rx_baud_nxt  = 1'b0;
        if (!rx_en) begin
            rx_state_nxt = RX_IDLE;
            rx_bit_nxt   = '0;
        end else if (rx_start_align) begin
            rx_state_nxt = RX_HALF;
            rx_bit_nxt   = '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    rx_bit_nxt = '0;
                end
                RX_HALF: begin
                    if (rx_os_c) begin
                        rx_os_nxt = 1'b1;
                        if (rx_bit == HALF_LAST) begin
                            rx_half_nxt  = 1'b1;
                            rx_state_nxt = RX_RUN;
                            rx_bit_nxt   = '0;
                        end else begin
                            rx_bit_nxt = rx_bit + BIT_W'(1);
                        end
                    end
                end
                RX_RUN: begin
                    if (rx_os_c) begin
                        rx_os_nxt = 1'b1;
                        if (rx_bit == BIT_LAST) begin
                            rx_baud_nxt = 1'b1;
                            rx_bit_nxt  = '0;
                        end else begin
                            rx_bit_nxt = rx_bit + BIT_W'(1);
                        end
                    end
                end
                default: begin
                    rx_state_nxt = RX_IDLE;
                    rx_bit_nxt   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Self-checking bench for baud_gen_frac: tick timestamps are compared against
// closed-form arrival times computed from the divisor.
module tb_baud_gen_frac;

    localparam int unsigned DIV_W  = 16;
    localparam int unsigned FRAC_W = 4;
    localparam int unsigned OSR    = 16;
    localparam int FSCALE = 1 << FRAC_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DIV_W-1:0]  cfg_div_int;
    logic [FRAC_W-1:0] cfg_div_frac;
    logic              cfg_load;
    logic              cfg_busy;
    logic              cfg_err;
    logic              tx_en;
    logic              rx_en;
    logic              rx_start_align;
    logic              tx_os_tick;
    logic              tx_baud_tick;
    logic              rx_os_tick;
    logic              rx_half_baud_tick;
    logic              rx_baud_tick;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int obs_q0[$], obs_q1[$], obs_q2[$], obs_q3[$], obs_q4[$];
    int exp_q0[$], exp_q1[$], exp_q2[$], exp_q3[$], exp_q4[$];

    baud_gen_frac dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cfg_div_int       (cfg_div_int),
        .cfg_div_frac      (cfg_div_frac),
        .cfg_load          (cfg_load),
        .cfg_busy          (cfg_busy),
        .cfg_err           (cfg_err),
        .tx_en             (tx_en),
        .rx_en             (rx_en),
        .rx_start_align    (rx_start_align),
        .tx_os_tick        (tx_os_tick),
        .tx_baud_tick      (tx_baud_tick),
        .rx_os_tick        (rx_os_tick),
        .rx_half_baud_tick (rx_half_baud_tick),
        .rx_baud_tick      (rx_baud_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Timestamp every tick with the index of the edge that produced it.
    always @(posedge clk) begin
        #1;
        if (tx_os_tick)        obs_q0.push_back(cyc);
        if (tx_baud_tick)      obs_q1.push_back(cyc);
        if (rx_os_tick)        obs_q2.push_back(cyc);
        if (rx_half_baud_tick) obs_q3.push_back(cyc);
        if (rx_baud_tick)      obs_q4.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Arrival edge of the k-th oversample tick after a start edge e0:
    // k whole periods plus the carries produced by the first k-1 accumulator adds.
    function automatic int tk(int e0, int k, int n, int f);
        return e0 + k * n + ((k - 1) * f) / FSCALE;
    endfunction

    function automatic int qsize(bit e, int sel);
        case (sel)
            0: return e ? exp_q0.size() : obs_q0.size();
            1: return e ? exp_q1.size() : obs_q1.size();
            2: return e ? exp_q2.size() : obs_q2.size();
            3: return e ? exp_q3.size() : obs_q3.size();
            default: return e ? exp_q4.size() : obs_q4.size();
        endcase
    endfunction

    function automatic int qget(bit e, int sel, int i);
        case (sel)
            0: return e ? exp_q0[i] : obs_q0[i];
            1: return e ? exp_q1[i] : obs_q1[i];
            2: return e ? exp_q2[i] : obs_q2[i];
            3: return e ? exp_q3[i] : obs_q3[i];
            default: return e ? exp_q4[i] : obs_q4[i];
        endcase
    endfunction

    task automatic clear_all();
        obs_q0.delete(); obs_q1.delete(); obs_q2.delete(); obs_q3.delete(); obs_q4.delete();
        exp_q0.delete(); exp_q1.delete(); exp_q2.delete(); exp_q3.delete(); exp_q4.delete();
    endtask

    task automatic cmp_all(input string tag);
        string names[5] = '{"tx_os", "tx_baud", "rx_os", "rx_half", "rx_baud"};
        for (int s = 0; s < 5; s++) begin
            int ne = qsize(1'b1, s);
            int no = qsize(1'b0, s);
            chk($sformatf("%s.%s.count", tag, names[s]), no, ne);
            for (int i = 0; i < ne && i < no; i++)
                chk($sformatf("%s.%s[%0d]", tag, names[s], i), qget(1'b0, s, i), qget(1'b1, s, i));
        end
    endtask

    task automatic build_tx(int e0, int last, int n, int f);
        int k = 1;
        int t = tk(e0, 1, n, f);
        while (t <= last) begin
            exp_q0.push_back(t);
            if (k % OSR == 0) exp_q1.push_back(t);
            k++;
            t = tk(e0, k, n, f);
        end
    endtask

    // RX ticks from an alignment edge a, up to but excluding edge stop.
    task automatic build_rx(int a, int stop, int n, int f);
        int k = 1;
        int t = tk(a, 1, n, f);
        while (t < stop) begin
            exp_q2.push_back(t);
            if (k == OSR / 2) exp_q3.push_back(t);
            if (k > OSR / 2 && (k - OSR / 2) % OSR == 0) exp_q4.push_back(t);
            k++;
            t = tk(a, k, n, f);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(int i, int f);
        @(negedge clk);
        cfg_div_int  = DIV_W'(i);
        cfg_div_frac = FRAC_W'(f);
        cfg_load     = 1'b1;
        @(negedge clk);
        cfg_load     = 1'b0;
    endtask

    // Run TX alone for w edges, optionally after loading a new divisor while idle.
    task automatic run_tx(input string tag, bit do_load, int n, int f, int w);
        int e0;
        if (do_load) begin
            load(n, f);
            chk({tag, ".busy_captured"}, 32'(cfg_busy), 32'd1);
            @(negedge clk);
            chk({tag, ".busy_applied"}, 32'(cfg_busy), 32'd0);
        end
        step(1);
        clear_all();
        @(negedge clk);
        tx_en = 1'b1;
        e0 = cyc + 1;
        step(w);
        tx_en = 1'b0;
        step(2);
        build_tx(e0, e0 + w - 1, n, f);
        cmp_all(tag);
    endtask

    // RX: align at a1, re-align off2 edges later, run w edges, then disable.
    task automatic run_rx(input string tag, int n, int f, int off2, int w);
        int a1, a2;
        load(n, f);
        step(2);
        clear_all();
        @(negedge clk);
        rx_en = 1'b1;
        step(3);
        rx_start_align = 1'b1;
        a1 = cyc + 1;
        @(negedge clk);
        rx_start_align = 1'b0;
        step(off2 - 1);
        rx_start_align = 1'b1;
        a2 = cyc + 1;
        @(negedge clk);
        rx_start_align = 1'b0;
        step(w - 1);
        // Disable together with an align pulse, then align again while disabled.
        rx_en = 1'b0;
        rx_start_align = 1'b1;
        @(negedge clk);
        rx_start_align = 1'b0;
        step(3);
        rx_start_align = 1'b1;
        @(negedge clk);
        rx_start_align = 1'b0;
        step(8 * n * 2);
        build_rx(a1, a2, n, f);
        build_rx(a2, a2 + w, n, f);
        cmp_all(tag);
    endtask

    initial begin
        int n, f, e0, ok;
        rst_n          = 1'b1;
        cfg_div_int    = '0;
        cfg_div_frac   = '0;
        cfg_load       = 1'b0;
        tx_en          = 1'b0;
        rx_en          = 1'b0;
        rx_start_align = 1'b0;

        #1;
        chk("rst.tx_os",   32'(tx_os_tick), 32'd0);
        chk("rst.tx_baud", 32'(tx_baud_tick), 32'd0);
        chk("rst.rx_os",   32'(rx_os_tick), 32'd0);
        chk("rst.rx_half", 32'(rx_half_baud_tick), 32'd0);
        chk("rst.rx_baud", 32'(rx_baud_tick), 32'd0);
        chk("rst.busy",    32'(cfg_busy), 32'd0);
        chk("rst.err",     32'(cfg_err), 32'd0);
        step(3);
        rst_n = 1'b0;
        step(2);

        // Default divisor after reset: 27 + 2/16.
        run_tx("def", 1'b0, 27, 2, 500);

        // Directed integer and fractional TX.
        run_tx("tx_int4", 1'b1, 4, 0, 200);
        run_tx("tx_frac8", 1'b1, 4, 8, 200);

        // Random TX divisors.
        for (int it = 0; it < 3; it++) begin
            n = $urandom_range(2, 6);
            f = $urandom_range(0, FSCALE - 1);
            run_tx($sformatf("tx_rnd%0d", it), 1'b1, n, f, 16 * n * 2 + $urandom_range(0, 40));
        end

        // Directed RX alignment with a re-align at +100.
        run_rx("rx_dir", 4, 0, 100, 150);

        // Random RX.
        for (int it = 0; it < 3; it++) begin
            n = $urandom_range(2, 6);
            f = $urandom_range(0, FSCALE - 1);
            run_rx($sformatf("rx_rnd%0d", it), n, f, $urandom_range(40, 150), $urandom_range(100, 250));
        end

        // Config handshake: load while TX runs stays pending until TX stops.
        load(4, 0);
        step(2);
        clear_all();
        @(negedge clk);
        tx_en = 1'b1;
        e0 = cyc + 1;
        step(9);
        load(8, 0);
        chk("hs.busy_set", 32'(cfg_busy), 32'd1);
        step(60);
        chk("hs.busy_hold", 32'(cfg_busy), 32'd1);
        tx_en = 1'b0;
        build_tx(e0, cyc, 4, 0);
        @(negedge clk);
        chk("hs.busy_clear", 32'(cfg_busy), 32'd0);
        cmp_all("hs.old_period");
        run_tx("hs.new_period", 1'b0, 8, 0, 160);

        // Config error: divisor below 2 is rejected.
        load($urandom_range(0, 1), 5);
        chk("err.pulse", 32'(cfg_err), 32'd1);
        chk("err.busy", 32'(cfg_busy), 32'd0);
        @(negedge clk);
        chk("err.single", 32'(cfg_err), 32'd0);
        run_tx("err.period", 1'b0, 8, 0, 160);

        // Asynchronous reset mid-run with a pending load.
        load(4, 0);
        step(2);
        @(negedge clk);
        tx_en = 1'b1;
        rx_en = 1'b1;
        rx_start_align = 1'b1;
        @(negedge clk);
        rx_start_align = 1'b0;
        step(5);
        load(6, 0);
        chk("mrst.busy_pre", 32'(cfg_busy), 32'd1);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #2;
            if (tx_os_tick) begin
                ok = 1;
                break;
            end
        end
        chk("mrst.tick_seen", 32'(ok), 32'd1);
        rst_n = 1'b1;
        #1;
        chk("mrst.tx_os",   32'(tx_os_tick), 32'd0);
        chk("mrst.tx_baud", 32'(tx_baud_tick), 32'd0);
        chk("mrst.rx_os",   32'(rx_os_tick), 32'd0);
        chk("mrst.busy",    32'(cfg_busy), 32'd0);
        tx_en = 1'b0;
        rx_en = 1'b0;
        step(2);
        rst_n = 1'b0;
        step(2);
        run_tx("mrst.def", 1'b0, 27, 2, 500);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/baud_gen_frac.md
# baud_gen_frac

Parametrised fractional baud-rate generator for the UART TX/RX datapaths. It derives oversample and bit-rate strobes from the system clock using a runtime-programmable integer+fractional divisor. TX and RX each have an independent divider, and the RX divider has start-bit half-bit alignment. It sits between the register/config interface and the UART transmitter and receiver FSMs.

## Interface
- DIV_W, 16, width of integer divisor
- FRAC_W, 4, width of fractional divisor (units of 1/2^FRAC_W clock)
- OSR, 16, oversample ticks per bit; even, >= 4
- DEF_INT, 27, integer divisor after reset (50 MHz, 115200 baud, OSR 16)
- DEF_FRAC, 2, fractional divisor after reset
- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  reset rst_n, asynchronous, active-high
- cfg_div_int  in  DIV_W  requested integer divisor
- cfg_div_frac  in  FRAC_W  requested fractional divisor
- cfg_load  in  1  one-cycle request to load cfg_div_*
- cfg_busy  out  1  a load is pending, not yet applied
- cfg_err  out  1  one-cycle pulse: load rejected
- tx_en  in  1  run TX divider
- rx_en  in  1  run RX divider
- rx_start_align  in  1  one-cycle pulse: start-bit edge detected, restart RX phase
- tx_os_tick  out  1  TX oversample strobe
- tx_baud_tick  out  1  TX bit strobe
- rx_os_tick  out  1  RX oversample strobe
- rx_half_baud_tick  out  1  RX mid-start-bit strobe
- rx_baud_tick  out  1  RX bit-centre strobe

## Operation
- Active divisor act_int/act_frac; reset to DEF_INT/DEF_FRAC. Both dividers use it.
- Each divider has os_cnt (DIV_W), frac_acc (FRAC_W), bit_cnt (log2 OSR).
- Oversample period = act_int + c clocks, where c is the carry of the previous frac_acc update. At each os tick: frac_acc <= frac_acc + act_frac mod 2^FRAC_W; the carry lengthens the next period by 1. The first period after start is exactly act_int.
- TX: tx_en=0 clears all TX counters and holds ticks low. tx_en=1 counts. tx_baud_tick coincides with every OSR-th tx_os_tick.
- RX FSM: IDLE, HALF, RUN.
  - IDLE: counters cleared. rx_start_align with rx_en=1 goes to HALF with counters cleared.
  - HALF: after OSR/2 rx_os_ticks, pulse rx_half_baud_tick on the OSR/2-th tick, then go to RUN with bit_cnt=0.
  - RUN: pulse rx_baud_tick on every OSR-th rx_os_tick.
  - rx_start_align in HALF or RUN restarts HALF, with counters cleared that cycle.
  - rx_en=0 in any state returns to IDLE immediately. rx_start_align while rx_en=0 is ignored.
- Config:
  - cfg_load with cfg_div_int < 2: rejected; pulse cfg_err the next cycle; active and pending values unchanged.
  - A valid cfg_load captures the pending value and sets cfg_busy.
  - The pending value is applied on the first cycle with tx_en=0 and RX state IDLE. It may be applied in the load cycle's next cycle if already idle. cfg_busy clears the same cycle.
  - A new valid cfg_load while busy overwrites the pending value.

## Timing
- All outputs are registered and pulse for exactly one cycle.
- Reset values: all ticks 0, cfg_busy 0, cfg_err 0, RX state IDLE, counters 0.
- tx_os_tick: first assertion on the act_int-th clock edge after the first edge sampling tx_en=1, then once per period.
- With frac=0, tx_baud_tick has period OSR*act_int exactly.
- rx_half_baud_tick: (OSR/2)*act_int clocks after the edge sampling rx_start_align (frac=0). rx_baud_tick follows every OSR*act_int clocks after that.
- Simultaneous rx_start_align and rx_en deassert: rx_en wins (IDLE).
- Simultaneous cfg_load and apply condition: capture this cycle, apply next cycle.
- os_cnt never exceeds act_int. Carry is applied only on the period following the overflowing add.

## Test plan
- Reset: assert rst_n mid-run with tx_en=rx_en=1 → all ticks and cfg_busy drop asynchronously; after release, act_int=27, act_frac=2.
- TX integer: load int=4, frac=0; tx_en=1 → tx_os_tick every 4 cycles; tx_baud_tick first at 64 cycles, then every 64.
- TX fractional: int=4, frac=8 (FRAC_W=4) → os periods 4,4,5,4,5,…; first tx_baud_tick at 71 cycles, next 72 later.
- RX align: int=4, OSR=16, rx_en=1, pulse rx_start_align → rx_half_baud_tick at +32, rx_baud_tick at +96 and +160. A second align pulse at +100 → next half tick 32 cycles after it, no rx_baud_tick at +160.
- Config handshake: cfg_load int=8 while tx_en=1 → cfg_busy=1 and TX period stays 4; drop tx_en → cfg_busy falls next cycle; re-enable → period 8.
- Config error: cfg_load int=1 → cfg_err pulse for 1 cycle, cfg_busy stays 0, period unchanged.
